apb_read_sequencer: RTL and testbench
=====================================

# apb_read_sequencer

APB read initiator that fetches a run of consecutive 32-bit words from an APB slave and hands each word to local logic with a valid strobe. It is the read-side counterpart of the write-only APB master: it drives PSEL/PENABLE/PRWADDR with PWRITE held low, honours PREADY wait states, and flags any returned word that is not packed BCD. It sits beside the BCD arithmetic slave and reads back results after the write master has loaded operands.

## Interface

Parameters:
- TIMEOUT, 16, maximum consecutive ACCESS cycles with PREADY low before the burst is aborted (legal range 1..255)

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to begin a burst; ignored while busy
- base_addr  in  32  byte address of first word; sampled with start
- count  in  4  number of words to read (0 = no bus activity); sampled with start
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable (access phase)
- PWRITE  out  1  constant 0
- PRWADDR  out  32  APB address
- PRDATA1  in  32  slave read data
- PREADY  in  1  slave ready
- rd_data  out  32  captured read word
- rd_valid  out  1  one-cycle strobe: rd_data/rd_index/bcd_err are new
- rd_index  out  4  position of word in burst, 0-based
- bcd_err  out  1  captured word has at least one nibble > 9
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst end (normal or aborted)
- timeout  out  1  last burst aborted on TIMEOUT; held until next accepted start or reset

## Operation

- States: IDLE, SETUP, ACCESS.
- IDLE: PSEL=0, PENABLE=0, busy=0. On start=1 with count≠0: latch base_addr into PRWADDR, remaining=count, rd_index counter=0, clear timeout, go SETUP. start with count=0: no transition, no done, clear timeout.
- SETUP (one cycle): PSEL=1, PENABLE=0, busy=1. Always goes to ACCESS.
- ACCESS: PSEL=1, PENABLE=1, PRWADDR unchanged. Wait counter increments each cycle PREADY=0.
  - PREADY=1: capture PRDATA1 into rd_data, set rd_index, bcd_err = OR over 8 nibbles of (nibble > 9), pulse rd_valid. Decrement remaining. If remaining was 1: go IDLE, pulse done. Else PRWADDR += 4 (mod 2^32, wraps 0xFFFFFFFC→0), clear wait counter, go SETUP.
  - PREADY=0 and wait counter reaches TIMEOUT: go IDLE, pulse done, set timeout=1, no rd_valid.
- PRDATA1 is sampled only in ACCESS with PREADY=1; ignored elsewhere.
- start while busy: ignored, no effect on latched parameters.
- PRESET (any state, any cycle incl. mid-ACCESS): next edge all outputs 0, state IDLE, counters cleared; the interrupted transfer is abandoned without a strobe.

## Timing

- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PRWADDR=0, rd_data=0, rd_valid=0, rd_index=0, bcd_err=0, busy=0, done=0, timeout=0.
- start sampled at edge E: SETUP visible in cycle after E, ACCESS one cycle later.
- Zero wait states: each word occupies exactly 2 cycles (SETUP+ACCESS), back-to-back with no idle cycle; N words = 2N bus cycles.
- Each wait state adds 1 cycle to that word.
- rd_valid asserts in the cycle after the ACCESS cycle where PREADY=1; for the last word done asserts in the same cycle, and busy is already 0.
- Timeout: with PREADY stuck low, done/timeout assert TIMEOUT cycles after entering ACCESS.
- Earliest new start accepted: cycle in which done is high.

## Test plan

- Single read, no waits: base_addr=0x0, count=1, responder returns 0x00000309 -> PSEL high 2 cycles, one rd_valid with rd_data=0x00000309, rd_index=0, bcd_err=0, done coincident.
- Burst of 3 with waits: base_addr=0x4, count=3, PREADY low 2 cycles on second word, data 0x60000001/0x10000005/0x0000000C -> PRWADDR 0x4,0x8,0xC; rd_index 0,1,2; bcd_err only on third (nibble C); total 8 bus cycles.
- Address wrap: base_addr=0xFFFFFFFC, count=2 -> PRWADDR 0xFFFFFFFC then 0x00000000, two strobes.
- Timeout: TIMEOUT=16, count=2, PREADY held 0 -> done and timeout at 16th ACCESS cycle, no rd_valid, PSEL/PENABLE drop; next start clears timeout.
- Reset mid-burst: PRESET pulsed during ACCESS of word 1 of count=4 -> all outputs 0 next edge, no further bus activity, no done.
- Edge stimuli: count=0 start -> no bus activity, no done; start asserted during busy -> ignored, original burst completes with original count.

Source files
------------

// File: rtl/apb_read_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_read_sequencer: APB read initiator that bursts consecutive words to    |
// | local logic with a valid strobe and a packed-BCD check. Rev 1.0            |
// +----------------------------------------------------------------------------+
module apb_read_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [3:0]  count,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PRWADDR,
  input  logic [31:0] PRDATA1,
  input  logic        PREADY,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [3:0]  rd_index,
  output logic        bcd_err,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  // Abort on the edge that ends the TIMEOUT-th stalled ACCESS cycle.
  localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic [3:0] r_remaining;
  logic [3:0] r_index;
  logic [7:0] r_wait;
  logic       w_nibble_err;

  always_comb begin
    w_nibble_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (PRDATA1[i*4 +: 4] > 4'd9) w_nibble_err = 1'b1;
    end
  end

  assign PWRITE = 1'b0;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= S_IDLE;
      r_remaining <= 4'd0;
      r_index     <= 4'd0;
      r_wait      <= 8'd0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PRWADDR     <= 32'd0;
      rd_data     <= 32'd0;
      rd_valid    <= 1'b0;
      rd_index    <= 4'd0;
      bcd_err     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            timeout <= 1'b0;
            if (count != 4'd0) begin
              PRWADDR     <= base_addr;
              r_remaining <= count;
              r_index     <= 4'd0;
              r_wait      <= 8'd0;
              PSEL        <= 1'b1;
              busy        <= 1'b1;
              r_state     <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            rd_data     <= PRDATA1;
            rd_index    <= r_index;
            bcd_err     <= w_nibble_err;
            rd_valid    <= 1'b1;
            r_index     <= r_index + 4'd1;
            r_remaining <= r_remaining - 4'd1;
            r_wait      <= 8'd0;
            PENABLE     <= 1'b0;
            if (r_remaining == 4'd1) begin
              PSEL    <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              PRWADDR <= PRWADDR + 32'd4;
              r_state <= S_SETUP;
            end
          end else if (r_wait == c_wait_last) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            r_wait  <= 8'd0;
            r_state <= S_IDLE;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_read_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_apb_read_sequencer: directed self-checking bench for apb_read_sequencer |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_apb_read_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [3:0]  count = 4'd0;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PRWADDR;
  logic [31:0] PRDATA1 = 32'd0;
  logic        PREADY = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [3:0]  rd_index;
  logic        bcd_err, busy, done, timeout;

  int checks = 0;
  int errors = 0;

  // ctl = {PSEL, PENABLE, busy, rd_valid, done, timeout}
  typedef struct packed {
    logic        rdy;
    logic [31:0] din;
    logic [5:0]  ctl;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [3:0]  idx;
    logic        bcd;
  } row_t;

  apb_read_sequencer #(.TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .start(start), .base_addr(base_addr),
    .count(count), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PRWADDR(PRWADDR), .PRDATA1(PRDATA1), .PREADY(PREADY),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_index(rd_index),
    .bcd_err(bcd_err), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  function automatic row_t mk(input logic rdy, input logic [31:0] din,
                              input logic [5:0] ctl, input logic [31:0] addr,
                              input logic [31:0] rdata, input logic [3:0] idx,
                              input logic bcd);
    row_t r;
    r.rdy = rdy; r.din = din; r.ctl = ctl; r.addr = addr;
    r.rdata = rdata; r.idx = idx; r.bcd = bcd;
    return r;
  endfunction

  task automatic begin_burst(input logic [31:0] b, input logic [3:0] c);
    start = 1'b1; base_addr = b; count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    tick(); tick();
    checks++;
    if ({PSEL, PENABLE, PWRITE, PRWADDR, rd_data, rd_valid, rd_index,
         bcd_err, busy, done, timeout} !== 76'd0) begin
      errors++;
      $display("FAIL reset_all: got %h want 0", {PSEL, PENABLE, PWRITE, PRWADDR,
               rd_data, rd_valid, rd_index, bcd_err, busy, done, timeout});
    end
    checks++;
    if (PRWADDR !== 32'd0) begin
      errors++; $display("FAIL reset_addr: got %h want 0", PRWADDR);
    end
    PRESET = 1'b0;
    tick();
    checks++;
    if ({PSEL, busy, done} !== 3'b000) begin
      errors++; $display("FAIL reset_idle: got %b want 000", {PSEL, busy, done});
    end
  endtask

  task automatic test_single();
    row_t rows[$] = '{
      mk(1'b0, 32'h0,   6'b101000, 32'h0, 32'h0,   4'd0, 1'b0),
      mk(1'b1, 32'h309, 6'b111000, 32'h0, 32'h0,   4'd0, 1'b0),
      mk(1'b0, 32'h0,   6'b000110, 32'h0, 32'h309, 4'd0, 1'b0),
      mk(1'b0, 32'h0,   6'b000000, 32'h0, 32'h0,   4'd0, 1'b0)};
    begin_burst(32'h0, 4'd1);
    foreach (rows[k]) begin
      PREADY = rows[k].rdy; PRDATA1 = rows[k].rdy ? rows[k].din : 32'hDEADBEEF;
      checks++;
      if ({PSEL, PENABLE, busy, rd_valid, done, timeout} !== rows[k].ctl) begin
        errors++; $display("FAIL single_ctl c%0d: got %b want %b", k + 1,
                           {PSEL, PENABLE, busy, rd_valid, done, timeout}, rows[k].ctl);
      end
      if (rows[k].ctl[5]) begin
        checks++;
        if (PRWADDR !== rows[k].addr) begin
          errors++; $display("FAIL single_addr c%0d: got %h want %h", k + 1, PRWADDR, rows[k].addr);
        end
      end
      if (rows[k].ctl[2]) begin
        checks++;
        if ({rd_data, rd_index, bcd_err} !== {rows[k].rdata, rows[k].idx, rows[k].bcd}) begin
          errors++; $display("FAIL single_data c%0d: got %h/%0d/%b want %h/%0d/%b", k + 1,
                             rd_data, rd_index, bcd_err, rows[k].rdata, rows[k].idx, rows[k].bcd);
        end
      end
      tick();
    end
  endtask

  task automatic test_burst_waits();
    row_t rows[$] = '{
      mk(1'b0, 32'h0,        6'b101000, 32'h4, 32'h0,        4'd0, 1'b0),
      mk(1'b1, 32'h60000001, 6'b111000, 32'h4, 32'h0,        4'd0, 1'b0),
      mk(1'b0, 32'h0,        6'b101100, 32'h8, 32'h60000001, 4'd0, 1'b0),
      mk(1'b0, 32'h0,        6'b111000, 32'h8, 32'h0,        4'd0, 1'b0),
      mk(1'b0, 32'h0,        6'b111000, 32'h8, 32'h0,        4'd0, 1'b0),
      mk(1'b1, 32'h10000005, 6'b111000, 32'h8, 32'h0,        4'd0, 1'b0),
      mk(1'b0, 32'h0,        6'b101100, 32'hC, 32'h10000005, 4'd1, 1'b0),
      mk(1'b1, 32'h0000000C, 6'b111000, 32'hC, 32'h0,        4'd0, 1'b0),
      mk(1'b0, 32'h0,        6'b000110, 32'h0, 32'h0000000C, 4'd2, 1'b1),
      mk(1'b0, 32'h0,        6'b000000, 32'h0, 32'h0,        4'd0, 1'b0)};
    begin_burst(32'h4, 4'd3);
    foreach (rows[k]) begin
      PREADY = rows[k].rdy; PRDATA1 = rows[k].rdy ? rows[k].din : 32'hDEADBEEF;
      checks++;
      if ({PSEL, PENABLE, busy, rd_valid, done, timeout} !== rows[k].ctl) begin
        errors++; $display("FAIL burst_ctl c%0d: got %b want %b", k + 1,
                           {PSEL, PENABLE, busy, rd_valid, done, timeout}, rows[k].ctl);
      end
      if (rows[k].ctl[5]) begin
        checks++;
        if (PRWADDR !== rows[k].addr) begin
          errors++; $display("FAIL burst_addr c%0d: got %h want %h", k + 1, PRWADDR, rows[k].addr);
        end
      end
      if (rows[k].ctl[2]) begin
        checks++;
        if ({rd_data, rd_index, bcd_err} !== {rows[k].rdata, rows[k].idx, rows[k].bcd}) begin
          errors++; $display("FAIL burst_data c%0d: got %h/%0d/%b want %h/%0d/%b", k + 1,
                             rd_data, rd_index, bcd_err, rows[k].rdata, rows[k].idx, rows[k].bcd);
        end
      end
      tick();
    end
  endtask

  task automatic test_addr_wrap();
    row_t rows[$] = '{
      mk(1'b0, 32'h0,        6'b101000, 32'hFFFFFFFC, 32'h0,        4'd0, 1'b0),
      mk(1'b1, 32'h12345678, 6'b111000, 32'hFFFFFFFC, 32'h0,        4'd0, 1'b0),
      mk(1'b0, 32'h0,        6'b101100, 32'h00000000, 32'h12345678, 4'd0, 1'b0),
      mk(1'b1, 32'h9999999A, 6'b111000, 32'h00000000, 32'h0,        4'd0, 1'b0),
      mk(1'b0, 32'h0,        6'b000110, 32'h0,        32'h9999999A, 4'd1, 1'b1),
      mk(1'b0, 32'h0,        6'b000000, 32'h0,        32'h0,        4'd0, 1'b0)};
    begin_burst(32'hFFFFFFFC, 4'd2);
    foreach (rows[k]) begin
      PREADY = rows[k].rdy; PRDATA1 = rows[k].rdy ? rows[k].din : 32'hDEADBEEF;
      checks++;
      if ({PSEL, PENABLE, busy, rd_valid, done, timeout} !== rows[k].ctl) begin
        errors++; $display("FAIL wrap_ctl c%0d: got %b want %b", k + 1,
                           {PSEL, PENABLE, busy, rd_valid, done, timeout}, rows[k].ctl);
      end
      if (rows[k].ctl[5]) begin
        checks++;
        if (PRWADDR !== rows[k].addr) begin
          errors++; $display("FAIL wrap_addr c%0d: got %h want %h", k + 1, PRWADDR, rows[k].addr);
        end
      end
      if (rows[k].ctl[2]) begin
        checks++;
        if ({rd_data, rd_index, bcd_err} !== {rows[k].rdata, rows[k].idx, rows[k].bcd}) begin
          errors++; $display("FAIL wrap_data c%0d: got %h/%0d/%b want %h/%0d/%b", k + 1,
                             rd_data, rd_index, bcd_err, rows[k].rdata, rows[k].idx, rows[k].bcd);
        end
      end
      tick();
    end
  endtask

  // Spurious starts while busy, then a new burst accepted in the done cycle.
  task automatic test_back_to_back();
    row_t rows[$] = '{
      mk(1'b1, 32'h77777777, 6'b101000, 32'h200, 32'h0,  4'd0, 1'b0),
      mk(1'b1, 32'h00000011, 6'b111000, 32'h200, 32'h0,  4'd0, 1'b0),
      mk(1'b0, 32'h0,        6'b101100, 32'h204, 32'h11, 4'd0, 1'b0),
      mk(1'b1, 32'h00000022, 6'b111000, 32'h204, 32'h0,  4'd0, 1'b0),
      mk(1'b0, 32'h0,        6'b000110, 32'h0,   32'h22, 4'd1, 1'b0),
      mk(1'b0, 32'h0,        6'b101000, 32'h300, 32'h0,  4'd0, 1'b0),
      mk(1'b1, 32'h00000042, 6'b111000, 32'h300, 32'h0,  4'd0, 1'b0),
      mk(1'b0, 32'h0,        6'b000110, 32'h0,   32'h42, 4'd0, 1'b0),
      mk(1'b0, 32'h0,        6'b000000, 32'h0,   32'h0,  4'd0, 1'b0)};
    begin_burst(32'h200, 4'd2);
    foreach (rows[k]) begin
      PREADY = rows[k].rdy; PRDATA1 = rows[k].rdy ? rows[k].din : 32'hDEADBEEF;
      if (k <= 2) begin
        start = 1'b1; base_addr = 32'h800; count = 4'd5;
      end else if (k == 4) begin
        start = 1'b1; base_addr = 32'h300; count = 4'd1;
      end else begin
        start = 1'b0;
      end
      checks++;
      if ({PSEL, PENABLE, busy, rd_valid, done, timeout} !== rows[k].ctl) begin
        errors++; $display("FAIL b2b_ctl c%0d: got %b want %b", k + 1,
                           {PSEL, PENABLE, busy, rd_valid, done, timeout}, rows[k].ctl);
      end
      if (rows[k].ctl[5]) begin
        checks++;
        if (PRWADDR !== rows[k].addr) begin
          errors++; $display("FAIL b2b_addr c%0d: got %h want %h", k + 1, PRWADDR, rows[k].addr);
        end
      end
      if (rows[k].ctl[2]) begin
        checks++;
        if ({rd_data, rd_index, bcd_err} !== {rows[k].rdata, rows[k].idx, rows[k].bcd}) begin
          errors++; $display("FAIL b2b_data c%0d: got %h/%0d/%b want %h/%0d/%b", k + 1,
                             rd_data, rd_index, bcd_err, rows[k].rdata, rows[k].idx, rows[k].bcd);
        end
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_timeout();
    logic [5:0] exp;
    begin_burst(32'h100, 4'd2);
    PREADY = 1'b0;
    PRDATA1 = 32'h00000001;
    for (int k = 1; k <= 19; k++) begin
      if (k == 1)       exp = 6'b101000;
      else if (k <= 17) exp = 6'b111000;
      else if (k == 18) exp = 6'b000011;
      else              exp = 6'b000001;
      checks++;
      if ({PSEL, PENABLE, busy, rd_valid, done, timeout} !== exp) begin
        errors++; $display("FAIL timeout_ctl c%0d: got %b want %b", k,
                           {PSEL, PENABLE, busy, rd_valid, done, timeout}, exp);
      end
      if (exp[5]) begin
        checks++;
        if (PRWADDR !== 32'h100) begin
          errors++; $display("FAIL timeout_addr c%0d: got %h want 00000100", k, PRWADDR);
        end
      end
      tick();
    end
  endtask

  // Follows the timeout test: a zero-length start clears the held flag.
  task automatic test_count_zero();
    checks++;
    if (timeout !== 1'b1) begin
      errors++; $display("FAIL zero_pre_timeout: got %b want 1", timeout);
    end
    PREADY = 1'b1;
    begin_burst(32'h500, 4'd0);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if ({PSEL, PENABLE, busy, rd_valid, done, timeout} !== 6'b000000) begin
        errors++; $display("FAIL zero_ctl c%0d: got %b want 000000", k,
                           {PSEL, PENABLE, busy, rd_valid, done, timeout});
      end
      tick();
    end
    PREADY = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    row_t rows[$] = '{
      mk(1'b0, 32'h0,  6'b101000, 32'h40, 32'h0,  4'd0, 1'b0),
      mk(1'b1, 32'h99, 6'b111000, 32'h40, 32'h0,  4'd0, 1'b0),
      mk(1'b0, 32'h0,  6'b101100, 32'h44, 32'h99, 4'd0, 1'b0),
      mk(1'b1, 32'h55, 6'b111000, 32'h44, 32'h0,  4'd0, 1'b0)};
    begin_burst(32'h40, 4'd4);
    foreach (rows[k]) begin
      PREADY = rows[k].rdy; PRDATA1 = rows[k].rdy ? rows[k].din : 32'hDEADBEEF;
      if (k == 3) PRESET = 1'b1;
      checks++;
      if ({PSEL, PENABLE, busy, rd_valid, done, timeout} !== rows[k].ctl) begin
        errors++; $display("FAIL rstmid_ctl c%0d: got %b want %b", k + 1,
                           {PSEL, PENABLE, busy, rd_valid, done, timeout}, rows[k].ctl);
      end
      if (rows[k].ctl[5]) begin
        checks++;
        if (PRWADDR !== rows[k].addr) begin
          errors++; $display("FAIL rstmid_addr c%0d: got %h want %h", k + 1, PRWADDR, rows[k].addr);
        end
      end
      if (rows[k].ctl[2]) begin
        checks++;
        if ({rd_data, rd_index, bcd_err} !== {rows[k].rdata, rows[k].idx, rows[k].bcd}) begin
          errors++; $display("FAIL rstmid_data c%0d: got %h/%0d/%b want %h/%0d/%b", k + 1,
                             rd_data, rd_index, bcd_err, rows[k].rdata, rows[k].idx, rows[k].bcd);
        end
      end
      tick();
    end
    checks++;
    if ({PSEL, PENABLE, PWRITE, PRWADDR, rd_data, rd_valid, rd_index,
         bcd_err, busy, done, timeout} !== 76'd0) begin
      errors++;
      $display("FAIL rstmid_zero: got %h want 0", {PSEL, PENABLE, PWRITE, PRWADDR,
               rd_data, rd_valid, rd_index, bcd_err, busy, done, timeout});
    end
    PRESET = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({PSEL, PENABLE, busy, rd_valid, done, timeout} !== 6'b000000) begin
        errors++; $display("FAIL rstmid_quiet c%0d: got %b want 000000", k,
                           {PSEL, PENABLE, busy, rd_valid, done, timeout});
      end
      tick();
    end
    PREADY = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_waits();
    test_addr_wrap();
    test_back_to_back();
    test_timeout();
    test_count_zero();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
